// File: rtl/cnt_bus_pkg.sv
// Shared definitions for the cnt_top register bus: arbiter states, default
// widths and register address map.
package cnt_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC,
      ST_RWAIT,
      ST_DONE
   } arb_state_t;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 32;

   localparam logic [7:0] REG_ENABLE    = 8'h00;
   localparam logic [7:0] REG_CLEAR     = 8'h01;
   localparam logic [7:0] REG_MODE      = 8'h02;
   localparam logic [7:0] REG_LIMITS_LO = 8'h03;
   localparam logic [7:0] REG_LIMITS_HI = 8'h04;

   // Load value for the read wait counter (it counts down to zero inclusive).
   function automatic int unsigned wait_init(int unsigned rd_wait);
      return (rd_wait == 0) ? 0 : rd_wait - 1;
   endfunction

endpackage

// File: rtl/cnt_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping modulo N_REQ; returns one-hot, index and a valid flag.
module cnt_rr_pick #(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         onehot,
   output logic [$clog2(N_REQ)-1:0] idx,
   output logic                     valid
);

   localparam int unsigned IDX_W = $clog2(N_REQ);

   int unsigned pos;

   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      pos    = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         pos = (32'(ptr) + i) % N_REQ;
         if (!valid && req[pos]) begin
            valid       = 1'b1;
            idx         = IDX_W'(pos);
            onehot[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cnt_reg_arbiter.sv
// Round-robin arbiter serialising N_REQ requesters onto the single cnt_top
// register bus; registered bus outputs, per-requester grant and ack pulses.
module cnt_reg_arbiter
   import cnt_bus_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned RD_WAIT = 0
) (
   input  logic                      clk,
   input  logic                      xrst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          req_rw,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          ack,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      cs,
   output logic                      rw,
   output logic [ADDR_W-1:0]         addr,
   output logic [DATA_W-1:0]         wdata,
   input  logic [DATA_W-1:0]         rdata
);

   localparam int unsigned IDX_W     = $clog2(N_REQ);
   localparam logic [1:0]  WAIT_INIT = 2'(wait_init(RD_WAIT));

   arb_state_t        state, state_nx;
   logic [IDX_W-1:0]  ptr, ptr_nx, win, win_nx, pick_idx;
   logic [N_REQ-1:0]  pick_onehot, gnt_nx, ack_nx, win_oh;
   logic              pick_valid;
   logic [1:0]        wcnt, wcnt_nx;
   logic              cs_nx, rw_nx, rw_sel;
   logic [ADDR_W-1:0] addr_nx, addr_sel;
   logic [DATA_W-1:0] wdata_nx, wdata_sel, rd_data_nx;

   cnt_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   always_comb begin
      addr_sel  = '0;
      wdata_sel = '0;
      rw_sel    = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (pick_onehot[i]) begin
            addr_sel  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_sel = req_wdata[i*DATA_W +: DATA_W];
            rw_sel    = req_rw[i];
         end
      end
   end

   always_comb begin
      win_oh      = '0;
      win_oh[win] = 1'b1;
   end

   always_comb begin
      state_nx   = state;
      ptr_nx     = ptr;
      win_nx     = win;
      wcnt_nx    = wcnt;
      gnt_nx     = '0;
      ack_nx     = '0;
      cs_nx      = cs;
      rw_nx      = rw;
      addr_nx    = addr;
      wdata_nx   = wdata;
      rd_data_nx = rd_data;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_nx = ST_ACC;
               win_nx   = pick_idx;
               ptr_nx   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
               gnt_nx   = pick_onehot;
               cs_nx    = 1'b1;
               rw_nx    = rw_sel;
               addr_nx  = addr_sel;
               wdata_nx = wdata_sel;
            end
         end
         ST_ACC: begin
            // rw still holds the latched direction of the access in flight
            if (rw || RD_WAIT == 0) begin
               if (!rw) rd_data_nx = rdata;
               cs_nx    = 1'b0;
               rw_nx    = 1'b0;
               ack_nx   = win_oh;
               state_nx = ST_DONE;
            end else begin
               wcnt_nx  = WAIT_INIT;
               state_nx = ST_RWAIT;
            end
         end
         ST_RWAIT: begin
            if (wcnt == 2'd0) begin
               rd_data_nx = rdata;
               cs_nx      = 1'b0;
               ack_nx     = win_oh;
               state_nx   = ST_DONE;
            end else begin
               wcnt_nx = wcnt - 1'b1;
            end
         end
         ST_DONE: begin
            addr_nx  = '0;
            wdata_nx = '0;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         win     <= '0;
         wcnt    <= '0;
         gnt     <= '0;
         ack     <= '0;
         cs      <= 1'b0;
         rw      <= 1'b0;
         addr    <= '0;
         wdata   <= '0;
         rd_data <= '0;
      end else begin
         state   <= state_nx;
         ptr     <= ptr_nx;
         win     <= win_nx;
         wcnt    <= wcnt_nx;
         gnt     <= gnt_nx;
         ack     <= ack_nx;
         cs      <= cs_nx;
         rw      <= rw_nx;
         addr    <= addr_nx;
         wdata   <= wdata_nx;
         rd_data <= rd_data_nx;
      end
   end

endmodule

// File: tb/tb_cnt_reg_arbiter.sv
// Bench for cnt_reg_arbiter: instances with RD_WAIT 0 and 2, directed literal
// checks plus randomized requesters against a transaction-timeline model.
module tb_cnt_reg_arbiter;
   import cnt_bus_pkg::*;

   localparam int unsigned N        = 4;
   localparam int unsigned AW       = 8;
   localparam int unsigned DW       = 32;
   localparam int unsigned NI       = 2;
   localparam int unsigned RAND_CYC = 4000;

   logic            clk = 1'b0;
   logic            xrst;
   logic [N-1:0]    req       [NI];
   logic [N-1:0]    req_rw    [NI];
   logic [N*AW-1:0] req_addr  [NI];
   logic [N*DW-1:0] req_wdata [NI];
   logic [N-1:0]    gnt       [NI];
   logic [N-1:0]    ack       [NI];
   logic [DW-1:0]   rd_data   [NI];
   logic            cs        [NI];
   logic            rw        [NI];
   logic [AW-1:0]   addr      [NI];
   logic [DW-1:0]   wdata     [NI];
   logic [DW-1:0]   rdata     [NI];

   always #5 clk = ~clk;

   cnt_reg_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(0)) dut0 (
      .clk(clk), .xrst(xrst), .req(req[0]), .req_rw(req_rw[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .gnt(gnt[0]), .ack(ack[0]), .rd_data(rd_data[0]),
      .cs(cs[0]), .rw(rw[0]), .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0])
   );

   cnt_reg_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_WAIT(2)) dut1 (
      .clk(clk), .xrst(xrst), .req(req[1]), .req_rw(req_rw[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .gnt(gnt[1]), .ack(ack[1]), .rd_data(rd_data[1]),
      .cs(cs[1]), .rw(rw[1]), .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1])
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int unsigned rd_wait_of(int unsigned k);
      return (k == 0) ? 0 : 2;
   endfunction

   // Model: each access is a timeline starting at the grant cycle t0 --
   // cs for len cycles, ack at t0+len, idle at t0+len+1, next pick at t0+len+2.
   int            cyc;
   int            t0     [NI];
   int            freeat [NI];
   int unsigned   len    [NI];
   int unsigned   win    [NI];
   int unsigned   mptr   [NI];
   logic          mwr    [NI];
   logic [AW-1:0] maddr  [NI];
   logic [DW-1:0] mwdata [NI];
   logic [DW-1:0] mrd    [NI];
   int unsigned   m_c;
   bit            m_found;
   int            m_ph;

   logic [N-1:0]  e_gnt   [NI];
   logic [N-1:0]  e_ack   [NI];
   logic          e_cs    [NI];
   logic          e_rw    [NI];
   logic [AW-1:0] e_addr  [NI];
   logic [DW-1:0] e_wdata [NI];
   logic [DW-1:0] e_rd    [NI];

   always @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         cyc = 0;
         for (int k = 0; k < NI; k++) begin
            t0[k] = -1; freeat[k] = 0; mptr[k] = 0; mrd[k] = '0;
            e_gnt[k] = '0; e_ack[k] = '0; e_cs[k] = 1'b0; e_rw[k] = 1'b0;
            e_addr[k] = '0; e_wdata[k] = '0; e_rd[k] = '0;
         end
      end else begin
         cyc++;
         for (int k = 0; k < NI; k++) begin
            if (t0[k] >= 0 && !mwr[k] && cyc == t0[k] + int'(len[k])) mrd[k] = rdata[k];
            if (t0[k] >= 0 && cyc >= freeat[k]) t0[k] = -1;
            if (t0[k] < 0 && cyc >= freeat[k] && req[k] != '0) begin
               m_found = 1'b0;
               for (int j = 0; j < N; j++) begin
                  m_c = (mptr[k] + j) % N;
                  if (!m_found && req[k][m_c]) begin
                     m_found = 1'b1;
                     win[k]  = m_c;
                  end
               end
               t0[k]     = cyc;
               mwr[k]    = req_rw[k][win[k]];
               maddr[k]  = req_addr[k][win[k]*AW +: AW];
               mwdata[k] = req_wdata[k][win[k]*DW +: DW];
               len[k]    = mwr[k] ? 1 : 1 + rd_wait_of(k);
               mptr[k]   = (win[k] + 1) % N;
               freeat[k] = cyc + int'(len[k]) + 2;
            end
            e_gnt[k] = '0; e_ack[k] = '0; e_cs[k] = 1'b0; e_rw[k] = 1'b0;
            e_addr[k] = '0; e_wdata[k] = '0;
            if (t0[k] >= 0) begin
               m_ph = cyc - t0[k];
               if (m_ph < int'(len[k])) begin
                  e_cs[k] = 1'b1; e_rw[k] = mwr[k]; e_addr[k] = maddr[k]; e_wdata[k] = mwdata[k];
                  if (m_ph == 0) e_gnt[k][win[k]] = 1'b1;
               end else if (m_ph == int'(len[k])) begin
                  e_ack[k][win[k]] = 1'b1; e_addr[k] = maddr[k]; e_wdata[k] = mwdata[k];
               end
            end
            e_rd[k] = mrd[k];
         end
      end
   end

   bit cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < NI; k++) begin
            chk($sformatf("gnt%0d", k),     gnt[k],     e_gnt[k]);
            chk($sformatf("ack%0d", k),     ack[k],     e_ack[k]);
            chk($sformatf("cs%0d", k),      cs[k],      e_cs[k]);
            chk($sformatf("rw%0d", k),      rw[k],      e_rw[k]);
            chk($sformatf("addr%0d", k),    addr[k],    e_addr[k]);
            chk($sformatf("wdata%0d", k),   wdata[k],   e_wdata[k]);
            chk($sformatf("rd_data%0d", k), rd_data[k], e_rd[k]);
         end
      end
   end

   task automatic wait_gnt(input int unsigned k, output int idx);
      idx = -1;
      for (int t = 0; t < 20 && idx < 0; t++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) if (gnt[k][i]) idx = i;
      end
      if (idx < 0) begin
         checks++;
         errors++;
         $display("FAIL gnt_timeout%0d actual=none required=grant", k);
      end
   endtask

   bit pend    [NI][N];
   bit granted [NI][N];
   int g;

   initial begin
      xrst = 1'b0;
      for (int k = 0; k < NI; k++) begin
         req[k] = '0; req_rw[k] = '0; req_addr[k] = '0; req_wdata[k] = '0; rdata[k] = '0;
      end
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      chk("rst_cs", cs[0], 0);
      chk("rst_gnt", gnt[0], 0);
      chk("rst_ack", ack[1], 0);
      chk("rst_rd_data", rd_data[1], 0);
      xrst = 1'b1;

      // single write on requester 0
      req_rw[0][0] = 1'b1;
      req_addr[0][0 +: AW] = REG_LIMITS_LO;
      req_wdata[0][0 +: DW] = 32'h05040302;
      req[0][0] = 1'b1;
      @(negedge clk);
      chk("wr_gnt", gnt[0], 4'b0001);
      chk("wr_cs", cs[0], 1);
      chk("wr_rw", rw[0], 1);
      chk("wr_addr", addr[0], 8'h03);
      chk("wr_wdata", wdata[0], 32'h05040302);
      chk("wr_ack_early", ack[0], 0);
      @(negedge clk);
      chk("wr_ack", ack[0], 4'b0001);
      chk("wr_cs_drop", cs[0], 0);
      chk("wr_gnt_clr", gnt[0], 0);
      req[0][0] = 1'b0;
      @(negedge clk);
      chk("wr_addr_clr", addr[0], 0);
      chk("wr_rd_keep", rd_data[0], 0);

      // read on requester 2, no wait states
      rdata[0] = 32'hFF;
      req_rw[0][2] = 1'b0;
      req_addr[0][2*AW +: AW] = REG_ENABLE;
      req[0][2] = 1'b1;
      @(negedge clk);
      chk("rd_gnt", gnt[0], 4'b0100);
      chk("rd_cs", cs[0], 1);
      @(negedge clk);
      chk("rd_ack", ack[0], 4'b0100);
      chk("rd_data", rd_data[0], 32'hFF);
      req[0][2] = 1'b0;
      rdata[0] = 32'h1234;
      @(negedge clk);
      chk("rd_hold", rd_data[0], 32'hFF);

      // read with two wait states: rdata must be taken at the last cs edge
      rdata[1] = 32'h11;
      req_rw[1][3] = 1'b0;
      req_addr[1][3*AW +: AW] = REG_MODE;
      req[1][3] = 1'b1;
      @(negedge clk);
      chk("rw2_gnt", gnt[1], 4'b1000);
      rdata[1] = 32'h22;
      @(negedge clk);
      chk("rw2_cs1", cs[1], 1);
      rdata[1] = 32'h33;
      @(negedge clk);
      chk("rw2_cs2", cs[1], 1);
      chk("rw2_noack", ack[1], 0);
      rdata[1] = 32'h44;
      @(negedge clk);
      chk("rw2_ack", ack[1], 4'b1000);
      chk("rw2_cs_drop", cs[1], 0);
      chk("rw2_data", rd_data[1], 32'h44);
      req[1][3] = 1'b0;
      repeat (2) @(negedge clk);

      // reset while dut1 waits on a read and dut0 is mid-write
      req_rw[1][1] = 1'b0;
      req[1][1] = 1'b1;
      @(negedge clk);
      req_rw[0][0] = 1'b1;
      req[0][0] = 1'b1;
      @(negedge clk);
      chk("pre_rst_cs0", cs[0], 1);
      chk("pre_rst_cs1", cs[1], 1);
      #2 xrst = 1'b0;
      #1;
      chk("arst_cs0", cs[0], 0);
      chk("arst_cs1", cs[1], 0);
      chk("arst_gnt0", gnt[0], 0);
      chk("arst_ack1", ack[1], 0);
      req[1] = '0;
      req_rw[0] = 4'b1111;
      for (int i = 0; i < N; i++) begin
         req_addr[0][i*AW +: AW] = AW'(8'h10 + i);
         req_wdata[0][i*DW +: DW] = $urandom;
      end
      req[0] = 4'b1111;
      @(negedge clk);
      xrst = 1'b1;
      for (int n = 0; n < 5; n++) begin
         wait_gnt(0, g);
         chk($sformatf("rr_order%0d", n), g, n % 4);
      end

      // fairness: requester 1 held, requester 3 arrives later
      req[0] = 4'b0010;
      wait_gnt(0, g);
      chk("fair_first", g, 1);
      req[0][3] = 1'b1;
      wait_gnt(0, g);
      chk("fair_late", g, 3);
      wait_gnt(0, g);
      chk("fair_again", g, 1);
      req[0] = '0;
      repeat (6) @(negedge clk);

      for (int k = 0; k < NI; k++)
         for (int i = 0; i < N; i++) begin
            pend[k][i] = 1'b0;
            granted[k][i] = 1'b0;
         end
      repeat (RAND_CYC) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < NI; k++) begin
            rdata[k] = $urandom;
            for (int i = 0; i < N; i++) begin
               if (ack[k][i]) begin
                  req[k][i] = 1'b0; pend[k][i] = 1'b0; granted[k][i] = 1'b0;
               end else if (gnt[k][i]) begin
                  // latched at grant, so later input changes must not leak onto the bus
                  granted[k][i] = 1'b1;
                  req_addr[k][i*AW +: AW] = AW'($urandom);
                  req_wdata[k][i*DW +: DW] = $urandom;
               end else if (pend[k][i] && !granted[k][i] && $urandom_range(0, 15) == 0) begin
                  req[k][i] = 1'b0; pend[k][i] = 1'b0;
               end else if (!pend[k][i] && $urandom_range(0, 3) == 0) begin
                  pend[k][i] = 1'b1;
                  req_rw[k][i] = 1'($urandom_range(0, 1));
                  req_addr[k][i*AW +: AW] = AW'($urandom);
                  req_wdata[k][i*DW +: DW] = $urandom;
                  req[k][i] = 1'b1;
               end
            end
         end
      end
      for (int k = 0; k < NI; k++) req[k] = '0;
      repeat (10) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
